// File: rtl/qmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : qmem_pkg
// Purpose  : Shared FSM encoding and sizing helpers for the qmem arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package qmem_pkg;

    localparam int MN_MAX = 8;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // Width of a master index; a single master still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/qmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : qmem_arbiter_if
// Purpose  : Bundles the N master-side and single slave-side qmem signals.
// Revision : 1.0 - initial release
// ============================================================================
interface qmem_arbiter_if #(
    parameter int QAW = 32,
    parameter int QDW = 32,
    parameter int QSW = QDW / 8,
    parameter int MN  = 2
);
    logic [MN-1:0]     qm_cs;
    logic [MN-1:0]     qm_we;
    logic [MN*QAW-1:0] qm_adr;
    logic [MN*QSW-1:0] qm_sel;
    logic [MN*QDW-1:0] qm_dat_w;
    logic [MN*QDW-1:0] qm_dat_r;
    logic [MN-1:0]     qm_ack;
    logic [MN-1:0]     qm_err;

    logic              qs_cs;
    logic              qs_we;
    logic [QAW-1:0]    qs_adr;
    logic [QSW-1:0]    qs_sel;
    logic [QDW-1:0]    qs_dat_w;
    logic [QDW-1:0]    qs_dat_r;
    logic              qs_ack;
    logic              qs_err;

    logic [MN-1:0]     gnt;

    // The arbiter is the shared target of the initiators.
    modport slave (
        input  qm_cs, qm_we, qm_adr, qm_sel, qm_dat_w,
        input  qs_dat_r, qs_ack, qs_err,
        output qm_dat_r, qm_ack, qm_err,
        output qs_cs, qs_we, qs_adr, qs_sel, qs_dat_w,
        output gnt
    );

    // Environment view: initiators plus the downstream target.
    modport master (
        output qm_cs, qm_we, qm_adr, qm_sel, qm_dat_w,
        output qs_dat_r, qs_ack, qs_err,
        input  qm_dat_r, qm_ack, qm_err,
        input  qs_cs, qs_we, qs_adr, qs_sel, qs_dat_w,
        input  gnt
    );
endinterface
`default_nettype wire

// File: rtl/qmem_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : qmem_rr_pick
// Purpose  : Combinational round-robin picker; scans last+1, last+2, ... mod MN.
// Revision : 1.0 - initial release
// ============================================================================
module qmem_rr_pick
    import qmem_pkg::*;
#(
    parameter int MN = 2
) (
    input  wire logic [MN-1:0]         req,
    input  wire logic [idx_w(MN)-1:0]  last,
    output logic      [MN-1:0]         pick,
    output logic      [idx_w(MN)-1:0]  idx,
    output logic                       valid
);
    localparam int LW = idx_w(MN);

    logic [LW-1:0] w_cand;
    logic          w_found;

    always_comb begin
        pick    = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= MN; k++) begin
            w_cand = LW'((int'(last) + k) % MN);
            if (!w_found && req[w_cand]) begin
                w_found      = 1'b1;
                pick[w_cand] = 1'b1;
                idx          = w_cand;
            end
        end
    end

    assign valid = |req;

endmodule
`default_nettype wire

// File: rtl/qmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qmem_arbiter
// Purpose  : N-master to 1-slave qmem arbiter, registered round-robin grant
//            locked for the duration of a transfer.
// Revision : 1.0 - initial release
// ============================================================================
module qmem_arbiter
    import qmem_pkg::*;
#(
    parameter int QAW = 32,
    parameter int QDW = 32,
    parameter int QSW = QDW / 8,
    parameter int MN  = 2
) (
    input  wire logic      clk,
    input  wire logic      rst,
    qmem_arbiter_if.slave  bus
);
    localparam int LW = idx_w(MN);

    logic [0:0]    r_state;
    logic [MN-1:0] r_gnt;
    logic [LW-1:0] r_gidx;
    logic [LW-1:0] r_last;

    logic [MN-1:0] w_pick;
    logic [LW-1:0] w_pick_idx;
    logic          w_req_any;
    logic          w_qs_cs;
    logic          w_done;

    qmem_rr_pick #(
        .MN    (MN)
    ) u_pick (
        .req   (bus.qm_cs),
        .last  (r_last),
        .pick  (w_pick),
        .idx   (w_pick_idx),
        .valid (w_req_any)
    );

    // r_gidx is the binary twin of r_gnt and drives every mux below.
    assign w_qs_cs = (r_state == ST_BUSY) && bus.qm_cs[r_gidx];
    assign w_done  = w_qs_cs && (bus.qs_ack || bus.qs_err);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= '0;
            r_gidx  <= '0;
            r_last  <= LW'(MN - 1);
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_gnt   <= w_pick;
                        r_gidx  <= w_pick_idx;
                        r_state <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_done) begin
                        r_last  <= r_gidx;
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end else if (!w_qs_cs) begin
                        // Initiator withdrew: abandon without moving the pointer.
                        r_gnt   <= '0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_gnt   <= '0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.qs_cs    = w_qs_cs;
    assign bus.qs_we    = bus.qm_we[r_gidx];
    assign bus.qs_adr   = bus.qm_adr[int'(r_gidx)*QAW +: QAW];
    assign bus.qs_sel   = bus.qm_sel[int'(r_gidx)*QSW +: QSW];
    assign bus.qs_dat_w = bus.qm_dat_w[int'(r_gidx)*QDW +: QDW];
    assign bus.gnt      = r_gnt;

    // Slave responses outside a live request belong to nobody.
    always_comb begin
        bus.qm_ack = '0;
        bus.qm_err = '0;
        if (w_qs_cs) begin
            bus.qm_ack[r_gidx] = bus.qs_ack;
            bus.qm_err[r_gidx] = bus.qs_err;
        end
    end

    for (genvar i = 0; i < MN; i++) begin : g_dat_r
        assign bus.qm_dat_r[i*QDW +: QDW] = bus.qs_dat_r;
    end

endmodule
`default_nettype wire
